// File: rtl/grover_pkg.sv
// Shared constants, types and the saturation helper for the Grover diffusion stage.
package grover_pkg;

   localparam int NUM_BIT    = 3;
   localparam int NUM_SAMPLE = 2**NUM_BIT;
   localparam int DATA_W     = 8;

   typedef logic signed [DATA_W-1:0]         amp_t;
   typedef logic signed [DATA_W+NUM_BIT-1:0] sum_t;
   typedef logic signed [DATA_W+1:0]         wide_t;
   typedef logic        [NUM_BIT-1:0]        idx_t;

   localparam idx_t  LAST_IDX = idx_t'(NUM_SAMPLE - 1);
   localparam wide_t AMP_MAX  = wide_t'(2**(DATA_W-1) - 1);
   localparam wide_t AMP_MIN  = wide_t'(-(2**(DATA_W-1)));

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      MEAN = 2'd1,
      EMIT = 2'd2
   } state_t;

   typedef struct packed {
      amp_t data;
      logic sat;
   } amp_sat_t;

   // Clamp a widened result into the amplitude range and flag any clipping.
   function automatic amp_sat_t sat_amp(input wide_t x);
      amp_sat_t r;
      if (x > AMP_MAX) begin
         r.data = amp_t'(AMP_MAX);
         r.sat  = 1'b1;
      end else if (x < AMP_MIN) begin
         r.data = amp_t'(AMP_MIN);
         r.sat  = 1'b1;
      end else begin
         r.data = amp_t'(x);
         r.sat  = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/grover_sample_buf.sv
// Amplitude buffer for one vector: synchronous write, combinational read.
module grover_sample_buf
   import grover_pkg::*;
(
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [NUM_BIT-1:0]       wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic [NUM_BIT-1:0]       rd_addr,
   output logic signed [DATA_W-1:0] rd_data
);

   amp_t mem [NUM_SAMPLE];

   // NOTE: the storage array has no reset; every entry is rewritten before it
   // is read, and leaving it unreset lets it map onto plain register/RAM cells.
   // NOTE: sequential state is assigned with <= so all flops update together.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/grover_diffusion.sv
// Grover diffusion stage: buffers a vector, then streams 2*mean - a[i].
// Define GROVER_DIFF_SAT_EN to clamp results (and flag out_sat) instead of wrapping.
module grover_diffusion
   import grover_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_last,
   output logic                     out_sat,
   output logic                     busy
);

   state_t   state;
   idx_t     cnt;
   idx_t     rd_idx;
   sum_t     sum;
   amp_t     mean;
   amp_t     rd_data;
   wide_t    diff;
   amp_sat_t res;

   assign in_ready = (state == LOAD);
   assign busy     = (state != LOAD);

   grover_sample_buf u_buf (
      .clk     (clk),
      .wr_en   (in_valid && in_ready),
      .wr_addr (cnt),
      .wr_data (in_data),
      .rd_addr (rd_idx),
      .rd_data (rd_data)
   );

   assign diff = (wide_t'(mean) <<< 1) - wide_t'(rd_data);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      rd_idx = cnt;
      res    = '0;
      // Once a sample is on the output, the next one to load is cnt+1.
      if (state == EMIT && out_valid) rd_idx = idx_t'(cnt + 1'b1);
`ifdef GROVER_DIFF_SAT_EN
      res = sat_amp(diff);
`else
      res.data = amp_t'(diff[DATA_W-1:0]);
      res.sat  = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= LOAD;
         cnt       <= '0;
         sum       <= '0;
         mean      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  sum <= sum + sum_t'(in_data);
                  if (cnt == LAST_IDX) begin
                     cnt   <= '0;
                     state <= MEAN;
                  end else begin
                     cnt <= idx_t'(cnt + 1'b1);
                  end
               end
            end
            MEAN: begin
               mean  <= amp_t'(sum >>> NUM_BIT);
               state <= EMIT;
            end
            EMIT: begin
               // Output registers only move on an empty slot or a handshake.
               if (!out_valid || out_ready) begin
                  if (out_valid && out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_sat   <= 1'b0;
                     sum       <= '0;
                     cnt       <= '0;
                     state     <= LOAD;
                  end else begin
                     out_valid <= 1'b1;
                     out_data  <= res.data;
                     out_sat   <= res.sat;
                     out_last  <= (rd_idx == LAST_IDX);
                     cnt       <= rd_idx;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_grover_diffusion.sv
// Self-checking bench for grover_diffusion: table of vectors plus backpressure and reset sequences.
module tb_grover_diffusion;
   import grover_pkg::*;

   typedef logic [NUM_SAMPLE-1:0][DATA_W-1:0] vec8_t;

   typedef struct packed {
      vec8_t                 din;
      vec8_t                 dout;
      logic [NUM_SAMPLE-1:0] sat;
   } vec_t;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_last;
   logic                     out_sat;
   logic                     busy;

   int total = 0;
   int bad   = 0;

   vec_t vecs [5];
   vec_t ramp;
   vec_t uni;

   grover_diffusion dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic vec8_t pk(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7);
      vec8_t v;
      v[0] = DATA_W'(a0); v[1] = DATA_W'(a1); v[2] = DATA_W'(a2); v[3] = DATA_W'(a3);
      v[4] = DATA_W'(a4); v[5] = DATA_W'(a5); v[6] = DATA_W'(a6); v[7] = DATA_W'(a7);
      return v;
   endfunction

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_vec(input vec8_t d);
      for (int i = 0; i < NUM_SAMPLE; i++) begin
         int guard = 0;
         in_valid = 1'b1;
         in_data  = $signed(d[i]);
         while (!in_ready && guard < 50) begin
            step();
            guard++;
         end
         if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
         step();
      end
      in_valid = 1'b0;
   endtask

   // Called right after the last input edge k: out_valid must rise after edge k+2.
   task automatic latency_check(input string name);
      check({name, "_busy_mean"}, busy, 1);
      check({name, "_in_ready_mean"}, in_ready, 0);
      check({name, "_valid_k1"}, out_valid, 0);
      step();
      check({name, "_valid_k2"}, out_valid, 0);
      step();
      check({name, "_valid_k3"}, out_valid, 1);
   endtask

   task automatic recv_vec(input string name, input vec_t v, input int stall_at, input int n);
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         while (!out_valid && guard < 20) begin
            step();
            guard++;
         end
         if (!out_valid) begin
            check({name, "_out_valid_timeout"}, 0, 1);
            return;
         end
         if (i == stall_at) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'sd99;
            for (int s = 0; s < 3; s++) begin
               step();
               check({name, "_stall_valid"}, out_valid, 1);
               check({name, "_stall_data"}, out_data, $signed(v.dout[i]));
               check({name, "_stall_last"}, out_last, 0);
               check({name, "_stall_in_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
         end
         check($sformatf("%s_data%0d", name, i), out_data, $signed(v.dout[i]));
         check($sformatf("%s_last%0d", name, i), out_last, (i == NUM_SAMPLE - 1) ? 1 : 0);
         check($sformatf("%s_sat%0d", name, i), out_sat, v.sat[i]);
         check($sformatf("%s_in_ready%0d", name, i), in_ready, 0);
         step();
      end
   endtask

   task automatic idle_check(input string name);
      check({name, "_idle_in_ready"}, in_ready, 1);
      check({name, "_idle_busy"}, busy, 0);
      check({name, "_idle_valid"}, out_valid, 0);
      check({name, "_idle_last"}, out_last, 0);
   endtask

   initial begin
      uni     = '{din: pk(16, 16, 16, 16, 16, 16, 16, 16),
                  dout: pk(16, 16, 16, 16, 16, 16, 16, 16), sat: '0};
      vecs[0] = uni;
      vecs[1] = '{din: pk(23, 23, 23, 23, 23, -23, 23, 23),
                  dout: pk(11, 11, 11, 11, 11, 57, 11, 11), sat: '0};
      vecs[2] = '{din: pk(-1, 0, 0, 0, 0, 0, 0, 0),
                  dout: pk(-1, -2, -2, -2, -2, -2, -2, -2), sat: '0};
`ifdef GROVER_DIFF_SAT_EN
      vecs[3] = '{din: pk(-100, 100, 100, 100, 100, 100, 100, 100),
                  dout: pk(127, 50, 50, 50, 50, 50, 50, 50), sat: 8'h01};
`else
      vecs[3] = '{din: pk(-100, 100, 100, 100, 100, 100, 100, 100),
                  dout: pk(-6, 50, 50, 50, 50, 50, 50, 50), sat: 8'h00};
`endif
      // Mean 28/8 floors to 3: outputs 6-i, all distinct so a lost or repeated sample shows.
      vecs[4] = '{din: pk(0, 1, 2, 3, 4, 5, 6, 7),
                  dout: pk(6, 5, 4, 3, 2, 1, 0, -1), sat: '0};
      ramp    = vecs[4];

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      step();

      // out_ready stays high while nothing is valid; it must be ignored then.
      out_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         send_vec(vecs[v].din);
         latency_check($sformatf("vec%0d", v));
         recv_vec($sformatf("vec%0d", v), vecs[v], -1, NUM_SAMPLE);
         idle_check($sformatf("vec%0d", v));
      end

      // Backpressure at index 2, with in_valid pushed during EMIT to prove it is ignored.
      send_vec(ramp.din);
      latency_check("bp");
      recv_vec("bp", ramp, 2, NUM_SAMPLE);
      idle_check("bp");

      // Reset after the 4th output of a vector, then a clean vector.
      send_vec(uni.din);
      latency_check("abort");
      recv_vec("abort", uni, -1, 4);
      rst = 1'b1;
      #1;
      check("abort_rst_valid", out_valid, 0);
      check("abort_rst_in_ready", in_ready, 1);
      check("abort_rst_busy", busy, 0);
      step();
      check("abort_rst_valid_edge", out_valid, 0);
      check("abort_rst_in_ready_edge", in_ready, 1);
      rst = 1'b0;
      send_vec(uni.din);
      latency_check("fresh");
      recv_vec("fresh", uni, -1, NUM_SAMPLE);
      idle_check("fresh");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
